// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcode encodings, FSM state codes and opcode classifiers shared by the HI/LO unit
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MADD  = 3'd4;
  localparam logic [2:0] OP_MSUB  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;
  function automatic logic is_mul(input logic [2:0] op);
    return op == OP_MULT || op == OP_MULTU || op == OP_MADD || op == OP_MSUB;
  endfunction
  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring divider on unsigned magnitudes, one quotient bit per enabled cycle
module muldiv_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             last_o
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] shifted, diff;
  // quot_q doubles as the dividend shift register: its MSB feeds the partial remainder
  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign diff = shifted - {1'b0, dvs_q};
  assign last_o = cnt_q == CW'(WIDTH - 1);
  assign quot_o = quot_q;
  assign rem_o = rem_q;
  always_comb begin
    rem_d = load_i ? '0 : en_i ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : rem_q;
    quot_d = load_i ? dividend_i : en_i ? {quot_q[WIDTH-2:0], ~diff[WIDTH]} : quot_q;
    dvs_d = load_i ? divisor_i : dvs_q;
    cnt_d = load_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rem_q <= '0;
      quot_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quot_q <= quot_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: MIPS-style HI/LO multiply, multiply-accumulate and multi-cycle divide unit
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);
  logic [1:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic done_q, done_d, dbz_q, dbz_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic accept, sgn, div_zero, div_load, div_last;
  logic [WIDTH-1:0] a_mag, b_mag, quot, rem, quot_s, rem_s;
  logic [2*WIDTH-1:0] ea, eb, prod, hilo;
  assign accept = Start && state_q == S_IDLE;
  assign sgn = Op == OP_DIV;
  assign a_mag = (sgn && A[WIDTH-1]) ? -A : A;
  assign b_mag = (sgn && B[WIDTH-1]) ? -B : B;
  assign div_zero = accept && is_div(Op) && B == '0;
  assign div_load = accept && is_div(Op) && B != '0;
  // only MULTU zero-extends; MADD/MSUB accumulate a signed product
  assign ea = {{WIDTH{op_q != OP_MULTU && a_q[WIDTH-1]}}, a_q};
  assign eb = {{WIDTH{op_q != OP_MULTU && b_q[WIDTH-1]}}, b_q};
  assign prod = ea * eb;
  assign hilo = op_q == OP_MADD ? {hi_q, lo_q} + prod : op_q == OP_MSUB ? {hi_q, lo_q} - prod : prod;
  assign quot_s = qneg_q ? -quot : quot;
  assign rem_s = rneg_q ? -rem : rem;
  muldiv_div_core #(.WIDTH(WIDTH)) u_div (
    .clk_i(Clk),
    .rst_ni(Rst_n),
    .load_i(div_load),
    .en_i(state_q == S_DIV),
    .dividend_i(a_mag),
    .divisor_i(b_mag),
    .quot_o(quot),
    .rem_o(rem),
    .last_o(div_last)
  );
  always_comb begin
    state_d = state_q == S_IDLE ? (accept && is_mul(Op) ? S_MUL : div_load ? S_DIV : S_IDLE) :
              state_q == S_DIV ? (div_last ? S_FIX : S_DIV) : S_IDLE;
    op_d = accept ? Op : op_q;
    a_d = accept ? A : a_q;
    b_d = accept ? B : b_q;
    hi_d = state_q == S_MUL ? hilo[2*WIDTH-1:WIDTH] : state_q == S_FIX ? rem_s :
           (accept && Op == OP_MTHI) ? A : hi_q;
    lo_d = state_q == S_MUL ? hilo[WIDTH-1:0] : state_q == S_FIX ? quot_s :
           (accept && Op == OP_MTLO) ? A : lo_q;
    done_d = (accept && (Op == OP_MTHI || Op == OP_MTLO)) || div_zero || state_q == S_MUL || state_q == S_FIX;
    dbz_d = accept ? div_zero : dbz_q;
    qneg_d = div_load ? sgn && (A[WIDTH-1] ^ B[WIDTH-1]) : qneg_q;
    rneg_d = div_load ? sgn && A[WIDTH-1] : rneg_q;
  end
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state_q <= S_IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      dbz_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      dbz_q <= dbz_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  assign Busy = state_q != S_IDLE;
  assign Done = done_q;
  assign Hi = hi_q;
  assign Lo = lo_q;
  assign DivByZero = dbz_q;
endmodule

// File: doc/muldiv_hilo_unit.md
MULDIV_HILO_UNIT -- requirements
Module: muldiv_hilo_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand and HI/LO width (WIDTH >= 4, even).
REQ-002 SHALL have ports in this order, as decided: Clk  in  1  sole clock, rising edge; Rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port: Start  in  1  operation request.
REQ-004 SHALL have port: Op  in  3  operation code: MULT, MULTU, DIV, DIVU, MADD, MSUB, MTHI, MTLO (encodings fixed in package).
REQ-005 SHALL have ports: A  in  WIDTH  rs operand; B  in  WIDTH  rt operand.
REQ-006 SHALL have ports: Busy  out  1  multi-cycle op in progress; Done  out  1  one-cycle completion pulse.
REQ-007 SHALL have ports: Hi  out  WIDTH  HI register; Lo  out  WIDTH  LO register (mfhi/mflo source).
REQ-008 SHALL have port: DivByZero  out  1  last accepted divide had B == 0.

Function
REQ-009 SHALL accept Start only when FSM is IDLE (Busy=0); Start while Busy=1 SHALL be ignored; Op/A/B SHALL be sampled only at the accepting edge.
REQ-010 SHALL implement FSM states IDLE, MUL, DIV, FIX; transitions: IDLE->MUL (MULT/MULTU/MADD/MSUB), IDLE->DIV (DIV/DIVU, B!=0), DIV->FIX after WIDTH iterations, MUL/FIX->IDLE.
REQ-011 MTHI/MTLO SHALL load Hi/Lo from A at the accepting edge; Done=1 in next cycle; Busy never asserted.
REQ-012 MULT/MULTU SHALL write the 2*WIDTH product as {Hi,Lo} at the edge ending MUL; Done=1 in cycle accept+2.
REQ-013 MADD/MSUB SHALL write {Hi,Lo} +/- signed product, modulo 2^(2*WIDTH); same latency as MULT.
REQ-014 DIV/DIVU SHALL use restoring division, one quotient bit per cycle on magnitudes; FIX applies signs; Lo=quotient, Hi=remainder; Done=1 in cycle accept+WIDTH+2.
REQ-015 Signed divide SHALL truncate quotient toward zero, remainder takes dividend sign; most-negative / -1 SHALL yield Lo=most-negative, Hi=0.
REQ-016 Divide with B==0 SHALL leave Hi/Lo unchanged, set DivByZero=1 at the accepting edge, Done=1 next cycle, Busy never asserted.
REQ-017 DivByZero SHALL clear at any other accepted Start.
REQ-018 Hi/Lo SHALL hold previous values throughout MUL/DIV/FIX until the final edge.
REQ-019 Busy SHALL be 1 from cycle after accept through the last MUL/DIV/FIX cycle; Busy=0 in the Done cycle, so a Start in the Done cycle SHALL be accepted (back-to-back).
REQ-020 Done SHALL be exactly one cycle wide per accepted operation.

Reset
REQ-021 Rst_n=0 SHALL immediately force IDLE, Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, independent of Clk.
REQ-022 Reset mid-operation SHALL abort it with no Hi/Lo update and no Done pulse.

Structure
REQ-023 Shared package muldiv_pkg SHALL hold Op encodings and FSM state localparams.
REQ-024 Divide iteration datapath (partial remainder, quotient shift, counter) SHALL be sub-module muldiv_div_core; multiply/accumulate stays in the top.

Verification
REQ-025 MULT A=0xFFFFFFFD, B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, Done at accept+2.
REQ-026 MULTU A=B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-027 DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, Done at accept+34, Busy high 33 cycles.
REQ-028 MTHI 0x1234, then DIV A=5, B=0 -> DivByZero=1, Hi=0x1234 unchanged, Done at accept+1.
REQ-029 MTHI 0, MTLO 0xFFFFFFFF, MADD A=1, B=1 -> Hi=1, Lo=0; then MSUB A=1, B=1 -> Hi=0, Lo=0xFFFFFFFF.
REQ-030 Start pulsed mid-DIV -> ignored; Rst_n low mid-DIV -> Hi=Lo=0, Busy=0, no Done.
